// File: rtl/sram_like_to_axi.sv
// Bridges the inst and data sram-like ports onto one AXI master.
// One transaction in flight at a time; the data port wins arbitration.
module sram_like_to_axi #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_W, S_B
  } state_e;

  state_e      state_q, state_d;
  logic        own_data_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        aw_done_q, w_done_q;
  logic        grant, grant_data, grant_wr;
  logic        aw_fire, w_fire, done_ok;
  logic [3:0]  id;
  logic        unused;

  assign unused = ^{rid, rresp, rlast, bid, bresp};

  assign grant      = (state_q == S_IDLE) && !rst
                      && (data_req || inst_req);
  assign grant_data = data_req;
  assign grant_wr   = grant_data ? data_wr : inst_wr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant) state_d = grant_wr ? S_W : S_AR;
      S_AR:   if (arready) state_d = S_R;
      S_R:    if (rvalid) state_d = S_IDLE;
      S_W:    if ((aw_done_q || awready) && (w_done_q || wready))
                state_d = S_B;
      S_B:    if (bvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and per-channel write completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      own_data_q <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      if (grant) begin
        own_data_q <= grant_data;
        wr_q       <= grant_wr;
        size_q     <= grant_data ? data_size : inst_size;
        addr_q     <= grant_data ? data_addr : inst_addr;
        wdata_q    <= grant_data ? data_wdata : inst_wdata;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
    end
  end

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // Output logic
  always_comb begin
    arvalid      = (state_q == S_AR);
    rready       = (state_q == S_R);
    awvalid      = (state_q == S_W) && !aw_done_q;
    wvalid       = (state_q == S_W) && !w_done_q;
    bready       = (state_q == S_B);
    data_addr_ok = grant && data_req;
    inst_addr_ok = grant && !data_req;
    done_ok      = !rst && ((rready && rvalid && !wr_q)
                   || (bready && bvalid && wr_q));
    data_data_ok = done_ok && own_data_q;
    inst_data_ok = done_ok && !own_data_q;
  end

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

  assign id      = own_data_q ? DATA_ID : INST_ID;
  assign arid    = id;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = id;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = id;
  assign wdata = wdata_q;
  assign wlast = 1'b1;

  always_comb begin
    wstrb = 4'b1111;
    unique case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Directed bench for sram_like_to_axi with a hand-driven AXI slave.
// Outputs are checked 1-2 ns after the rising edge.
module tb_sram_like_to_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_like_to_axi dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 0;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0;
    rlast = 1; rvalid = 0;
    awready = 0; wready = 0;
    bid = 0; bresp = 0; bvalid = 0;

    // reset state
    tick(); tick();
    inst_req = 1; inst_addr = 32'hBFC00000;
    settle();
    chk("rst_addr_ok", inst_addr_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_valids", {awvalid, wvalid, rready, bready}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);

    // inst read
    tick();
    rst = 0; inst_size = 2;
    settle();
    chk("ir_addr_ok", inst_addr_ok, 1);
    chk("ir_d_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 0;
    settle();
    chk("ir_arvalid", arvalid, 1);
    chk("ir_araddr", araddr, 32'hBFC00000);
    chk("ir_arid", arid, 0);
    chk("ir_arsize", arsize, 2);
    chk("ir_arconst", {arlen, arburst, arlock, arcache, arprot},
        {8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("ir_no_dok", inst_data_ok, 0);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h3C080001;
    settle();
    chk("ir_rready", rready, 1);
    chk("ir_data_ok", inst_data_ok, 1);
    chk("ir_rdata", inst_rdata, 32'h3C080001);
    chk("ir_d_dok", data_data_ok, 0);
    tick();
    rvalid = 0;
    settle();
    chk("ir_dok_pulse", inst_data_ok, 0);
    chk("ir_idle", {arvalid, rready}, 0);

    // simultaneous requests: data wins, inst waits
    inst_req = 1; inst_addr = 32'hBFC00010; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h80000100;
    data_size = 2;
    settle();
    chk("pr_d_addr_ok", data_addr_ok, 1);
    chk("pr_i_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 0;
    settle();
    chk("pr_arid_data", arid, 1);
    chk("pr_araddr", araddr, 32'h80000100);
    chk("pr_busy_aok", inst_addr_ok, 0);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h11223344;
    settle();
    chk("pr_d_dok", data_data_ok, 1);
    chk("pr_d_rdata", data_rdata, 32'h11223344);
    chk("pr_i_dok", inst_data_ok, 0);
    chk("pr_no_aok", inst_addr_ok, 0);
    tick();
    rvalid = 0;
    settle();
    chk("pr_i_granted", inst_addr_ok, 1);
    tick();
    inst_req = 0;
    settle();
    chk("pr_i_arid", arid, 0);
    chk("pr_i_araddr", araddr, 32'hBFC00010);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h55667788;
    settle();
    chk("pr_i_dok2", inst_data_ok, 1);
    tick();
    rvalid = 0;

    // byte write, aw and w ready at different times
    data_req = 1; data_wr = 1; data_size = 0;
    data_addr = 32'h80000003; data_wdata = 32'hAB000000;
    settle();
    chk("bw_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0;
    settle();
    chk("bw_vld", {awvalid, wvalid}, 2'b11);
    chk("bw_wstrb", wstrb, 4'b1000);
    chk("bw_awsize", awsize, 0);
    chk("bw_awaddr", awaddr, 32'h80000003);
    chk("bw_ids", {awid, wid}, 8'h11);
    chk("bw_wdata", wdata, 32'hAB000000);
    chk("bw_wlast", wlast, 1);
    chk("bw_no_ar", arvalid, 0);
    awready = 1;
    tick();
    awready = 0;
    settle();
    chk("bw_aw_drop", awvalid, 0);
    chk("bw_w_hold", wvalid, 1);
    chk("bw_no_b", bready, 0);
    tick();
    wready = 1;
    settle();
    chk("bw_w_hold2", wvalid, 1);
    chk("bw_wstrb2", wstrb, 4'b1000);
    chk("bw_no_b2", bready, 0);
    tick();
    wready = 0;
    settle();
    chk("bw_w_drop", wvalid, 0);
    chk("bw_bready", bready, 1);
    chk("bw_no_dok", data_data_ok, 0);
    bvalid = 1;
    settle();
    chk("bw_dok", data_data_ok, 1);
    chk("bw_i_dok", inst_data_ok, 0);
    tick();
    bvalid = 0;
    settle();
    chk("bw_dok_pulse", data_data_ok, 0);

    // half write, late bvalid
    data_req = 1; data_wr = 1; data_size = 1;
    data_addr = 32'h80000002; data_wdata = 32'hBEEF0000;
    settle();
    chk("hw_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; awready = 1; wready = 1;
    settle();
    chk("hw_wstrb", wstrb, 4'b1100);
    chk("hw_awsize", awsize, 1);
    tick();
    awready = 0; wready = 0;
    settle();
    chk("hw_bready", bready, 1);
    chk("hw_wait1", data_data_ok, 0);
    tick();
    chk("hw_wait2", data_data_ok, 0);
    tick();
    bvalid = 1;
    settle();
    chk("hw_dok", data_data_ok, 1);
    tick();
    bvalid = 0;
    settle();
    chk("hw_dok_pulse", data_data_ok, 0);

    // arready held low for five cycles
    data_req = 1; data_wr = 0; data_size = 2;
    data_addr = 32'h80001000;
    settle();
    chk("st_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0;
    inst_req = 1; inst_addr = 32'hBFC00020;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("st_arvalid", arvalid, 1);
      chk("st_araddr", araddr, 32'h80001000);
      chk("st_arid", arid, 1);
      chk("st_no_aok", {inst_addr_ok, data_addr_ok}, 0);
      chk("st_no_dok", {inst_data_ok, data_data_ok}, 0);
      tick();
    end
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'hCAFEF00D;
    settle();
    chk("st_dok", data_data_ok, 1);
    chk("st_rdata", data_rdata, 32'hCAFEF00D);
    chk("st_busy_aok", inst_addr_ok, 0);
    tick();
    rvalid = 0;

    // inst read reaches R, then reset
    settle();
    chk("rr_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; arready = 1;
    settle();
    chk("rr_arvalid", arvalid, 1);
    tick();
    arready = 0;
    settle();
    chk("rr_in_r", rready, 1);
    rst = 1; rvalid = 1; rdata = 32'hDEADDEAD;
    settle();
    chk("rr_rst_dok", {inst_data_ok, data_data_ok}, 0);
    tick();
    rst = 0; rvalid = 0;
    settle();
    chk("rr_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rr_no_dok", {inst_data_ok, data_data_ok}, 0);

    // fresh read after reset
    inst_req = 1; inst_addr = 32'hBFC00004; inst_size = 2;
    settle();
    chk("fr_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0;
    settle();
    chk("fr_araddr", araddr, 32'hBFC00004);
    chk("fr_arid", arid, 0);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h12345678;
    settle();
    chk("fr_dok", inst_data_ok, 1);
    chk("fr_rdata", inst_rdata, 32'h12345678);
    tick();
    rvalid = 0;
    settle();
    chk("fr_dok_pulse", inst_data_ok, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
